// File: rtl/clock_div_10_mhz_if.sv
// Derived decade clock outputs of the 10 MHz divider.
interface clock_div_10_mhz_if;
  logic CLOCK_1MHz;
  logic CLOCK_100KHz;
  logic CLOCK_10KHz;
  logic CLOCK_1KHz;
  logic CLOCK_100Hz;
  logic CLOCK_10Hz;
  logic CLOCK_1Hz;

  modport master (
    output CLOCK_1MHz, CLOCK_100KHz, CLOCK_10KHz, CLOCK_1KHz,
           CLOCK_100Hz, CLOCK_10Hz, CLOCK_1Hz
  );
  modport slave (
    input  CLOCK_1MHz, CLOCK_100KHz, CLOCK_10KHz, CLOCK_1KHz,
           CLOCK_100Hz, CLOCK_10Hz, CLOCK_1Hz
  );
endinterface

// File: rtl/clock_div_10_mhz.sv
// Seven-stage synchronous decade divider: mod-10 counters chained by
// terminal-count enables, each stage driving a registered 50 % output.
module clock_div_10_mhz_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tc,
  output logic o
);
  logic [3:0] c;

  // Out-of-range counts (10..15) are treated as terminal so they wrap.
  assign tc = (c >= 4'd9);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c <= 4'd0;
      o <= 1'b0;
    end else if (en) begin
      if (tc) begin
        c <= 4'd0;
        o <= 1'b0;
      end else begin
        c <= c + 4'd1;
        if (c == 4'd4) o <= 1'b1;
      end
    end
  end
endmodule

module clock_div_10_mhz #(
  parameter int STAGES = 7
) (
  input  logic                      CLOCK_10MHz,
  input  logic                      RESET_N,
  clock_div_10_mhz_if.master        div
);
  logic [STAGES:0]   en;
  logic [STAGES-1:0] tc;
  logic [STAGES-1:0] o;

  assign en[0] = RESET_N;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign en[k+1] = en[k] & tc[k];
    clock_div_10_mhz_stage u_stage (
      .clk   (CLOCK_10MHz),
      .rst_n (RESET_N),
      .en    (en[k]),
      .tc    (tc[k]),
      .o     (o[k])
    );
  end

  assign div.CLOCK_1MHz   = o[0];
  assign div.CLOCK_100KHz = o[1];
  assign div.CLOCK_10KHz  = o[2];
  assign div.CLOCK_1KHz   = o[3];
  assign div.CLOCK_100Hz  = o[4];
  assign div.CLOCK_10Hz   = o[5];
  assign div.CLOCK_1Hz    = o[6];
endmodule

// File: tb/tb_clock_div_10_mhz.sv
// Scoreboard bench: expected output vector per edge comes from the
// closed-form o_k = (n mod 10^k) >= 10^k/2, n = edges since reset release.
module tb_clock_div_10_mhz;
  logic CLOCK_10MHz = 1'b0;
  logic RESET_N = 1'b0;
  clock_div_10_mhz_if div ();

  clock_div_10_mhz dut (
    .CLOCK_10MHz (CLOCK_10MHz),
    .RESET_N     (RESET_N),
    .div         (div)
  );

  always #50 CLOCK_10MHz = ~CLOCK_10MHz;

  int total = 0;
  int bad = 0;
  longint n = 0;
  logic [6:0] exp_q[$];
  logic [6:0] prev = 7'd0;
  longint first_rise[7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [6:0] model(input longint cnt);
    logic [6:0] v;
    longint p;
    p = 10;
    for (int k = 0; k < 7; k++) begin
      v[k] = (cnt % p) >= (p / 2);
      p = p * 10;
    end
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {div.CLOCK_1Hz, div.CLOCK_10Hz, div.CLOCK_100Hz, div.CLOCK_1KHz,
            div.CLOCK_10KHz, div.CLOCK_100KHz, div.CLOCK_1MHz};
  endfunction

  // One clock edge: push the expectation, then sample 1 time unit later.
  task automatic step(input logic rst);
    logic [6:0] cur;
    logic [6:0] e;
    RESET_N = rst;
    @(posedge CLOCK_10MHz);
    if (!rst) begin
      n = 0;
      for (int k = 0; k < 7; k++) first_rise[k] = 0;
    end else n++;
    exp_q.push_back(model(n));
    #1;
    cur = outs();
    e = exp_q.pop_front();
    chk("outs", {25'd0, cur}, {25'd0, e});
    for (int k = 0; k < 7; k++)
      if (cur[k] && !prev[k] && first_rise[k] == 0) first_rise[k] = n;
    // A slower stage may only rise where the next faster stage falls.
    for (int k = 1; k < 7; k++)
      if (cur[k] && !prev[k] && rst)
        chk("cascade", {31'd0, prev[k-1] & ~cur[k-1]}, 32'd1);
    prev = cur;
  endtask

  initial begin
    for (int k = 0; k < 7; k++) first_rise[k] = 0;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("reset_outs", {25'd0, outs()}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("post_rel_e4", {25'd0, outs()}, 32'd0);
    step(1'b1);
    chk("1mhz_e5", {31'd0, div.CLOCK_1MHz}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1);
    chk("1mhz_e10", {31'd0, div.CLOCK_1MHz}, 32'd0);
    while (n < 12345) step(1'b1);
    // Mid-count reset for one edge, then restart from a clean state.
    step(1'b0);
    chk("midrst", {25'd0, outs()}, 32'd0);
    while (n < 50005) step(1'b1);
    chk("rise_1mhz", first_rise[0][31:0], 32'd5);
    chk("rise_100k", first_rise[1][31:0], 32'd50);
    chk("rise_10k", first_rise[2][31:0], 32'd500);
    chk("rise_1k", first_rise[3][31:0], 32'd5000);
    chk("rise_100hz", first_rise[4][31:0], 32'd50000);
    chk("q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
